qsys_system_led_driver: RTL and testbench

Downstream consumer of the 2-bit LED status PIO output in the Qsys system. Turns the registered status code into a visible LED pattern: off, solid, slow blink or double-pulse heartbeat. All patterns are dimmed by a free-running PWM. It sits between the PIO `out_port` and the board LED pin, in the same clock domain as the Avalon fabric.

---
 rtl/led_driver_pkg.sv | 43 ++++
 rtl/led_tick_gen.sv | 43 ++++
 rtl/qsys_system_led_driver.sv | 129 ++++++++++++
 tb/tb_qsys_system_led_driver.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/led_driver_pkg.sv
// -----------------------------------------------------------------------------
// led_driver_pkg
// Shared definitions for the status LED driver:
//   - led_state_t      : pattern FSM state encoding (3 bits, 0..7)
//   - MODE_*           : 2-bit status codes coming from the status PIO
//   - mode_init_state  : first pattern state entered for a given mode
//   - state_is_lit     : pattern level (before PWM) for a given state
// -----------------------------------------------------------------------------
package led_driver_pkg;

   typedef enum logic [2:0] {
      S_OFF       = 3'd0,
      S_SOLID     = 3'd1,
      S_BLINK_ON  = 3'd2,
      S_BLINK_OFF = 3'd3,
      S_HB_P1     = 3'd4,
      S_HB_G1     = 3'd5,
      S_HB_P2     = 3'd6,
      S_HB_REST   = 3'd7
   } led_state_t;

   localparam logic [1:0] MODE_OFF   = 2'b00;
   localparam logic [1:0] MODE_SOLID = 2'b01;
   localparam logic [1:0] MODE_BLINK = 2'b10;
   localparam logic [1:0] MODE_HB    = 2'b11;

   function automatic led_state_t mode_init_state(input logic [1:0] mode);
      led_state_t s;
      case (mode)
         MODE_SOLID: s = S_SOLID;
         MODE_BLINK: s = S_BLINK_ON;
         MODE_HB:    s = S_HB_P1;
         default:    s = S_OFF;
      endcase
      return s;
   endfunction

   function automatic logic state_is_lit(input led_state_t s);
      return (s == S_SOLID) || (s == S_BLINK_ON) ||
             (s == S_HB_P1) || (s == S_HB_P2);
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// -----------------------------------------------------------------------------
// led_tick_gen
// Pattern-tick prescaler. Counts 0..TICK_DIV-1 and raises tick for the one
// cycle in which the count sits at TICK_DIV-1; the count then wraps to 0.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   clr      in   synchronous clear of the count (takes priority over wrap)
//   tick     out  one-cycle pulse every TICK_DIV cycles
// -----------------------------------------------------------------------------
module led_tick_gen
   import led_driver_pkg::*;
#(
   parameter int TICK_DIV = 50000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      tick  = (cnt_q == CW'(TICK_DIV - 1));
      cnt_d = cnt_q + CW'(1);
      if (clr || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/qsys_system_led_driver.sv
// -----------------------------------------------------------------------------
// qsys_system_led_driver
// Turns the 2-bit LED status code from the status PIO into a visible pattern
// (off / solid / slow blink / double-pulse heartbeat), dimmed by a free-running
// PWM, and drives the board LED pin.
// Ports:
//   clk         in   system clock (Avalon fabric domain)
//   reset_n     in   asynchronous active-low reset
//   status      in   mode code: 00 off, 01 solid, 10 slow blink, 11 heartbeat
//   brightness  in   PWM duty; 0 = dark, all-ones = fully on
//   led         out  registered LED drive, active-high
//   phase_on    out  registered pattern level before PWM
//   pat_state   out  current pattern FSM state encoding
// -----------------------------------------------------------------------------
module qsys_system_led_driver
   import led_driver_pkg::*;
#(
   parameter int TICK_DIV      = 50000,
   parameter int SLOW_TICKS    = 500,
   parameter int HB_ON_TICKS   = 100,
   parameter int HB_GAP_TICKS  = 100,
   parameter int HB_REST_TICKS = 700,
   parameter int PWM_BITS      = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [1:0]          status,
   input  logic [PWM_BITS-1:0] brightness,
   output logic                led,
   output logic                phase_on,
   output logic [2:0]          pat_state
);

   localparam int MAX_AB  = (SLOW_TICKS > HB_ON_TICKS) ? SLOW_TICKS : HB_ON_TICKS;
   localparam int MAX_CD  = (HB_GAP_TICKS > HB_REST_TICKS) ? HB_GAP_TICKS : HB_REST_TICKS;
   localparam int MAX_DUR = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CNT_W   = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

   logic [1:0]          status_q, status_d;
   logic [1:0]          mode_q, mode_d;
   led_state_t          state_q, state_d;
   led_state_t          state_nxt;
   logic [CNT_W-1:0]    tick_cnt_q, tick_cnt_d;
   logic [CNT_W-1:0]    dur_m1;
   logic                timed;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic                phase_on_q, phase_on_d;
   logic                led_q, led_d;
   logic                mode_chg;
   logic                tick;
   logic                pwm_on;

   // The FSM follows the registered status. mode_q remembers which mode the
   // FSM is currently running, so a new code reaches the FSM one edge after
   // it is captured into status_q.
   led_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (mode_chg),
      .tick    (tick)
   );

   always_comb begin
      status_d   = status;
      mode_d     = status_q;
      mode_chg   = (status_q != mode_q);
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      dur_m1     = '0;
      state_nxt  = state_q;
      timed      = 1'b1;

      case (state_q)
         S_BLINK_ON:  begin dur_m1 = CNT_W'(SLOW_TICKS - 1);    state_nxt = S_BLINK_OFF; end
         S_BLINK_OFF: begin dur_m1 = CNT_W'(SLOW_TICKS - 1);    state_nxt = S_BLINK_ON;  end
         S_HB_P1:     begin dur_m1 = CNT_W'(HB_ON_TICKS - 1);   state_nxt = S_HB_G1;     end
         S_HB_G1:     begin dur_m1 = CNT_W'(HB_GAP_TICKS - 1);  state_nxt = S_HB_P2;     end
         S_HB_P2:     begin dur_m1 = CNT_W'(HB_ON_TICKS - 1);   state_nxt = S_HB_REST;   end
         S_HB_REST:   begin dur_m1 = CNT_W'(HB_REST_TICKS - 1); state_nxt = S_HB_P1;     end
         default:     timed = 1'b0;   // S_OFF / S_SOLID hold until the mode changes
      endcase

      // A mode change wins over a tick landing in the same cycle.
      if (mode_chg) begin
         state_d    = mode_init_state(status_q);
         tick_cnt_d = '0;
      end else if (tick && timed) begin
         if (tick_cnt_q == dur_m1) begin
            state_d    = state_nxt;
            tick_cnt_d = '0;
         end else begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
         end
      end

      pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
      // All-ones brightness must be fully on, not (2^N-1)/2^N.
      pwm_on     = (pwm_cnt_q < brightness) || (&brightness);
      phase_on_d = state_is_lit(state_d);
      led_d      = phase_on_d & pwm_on;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         status_q   <= MODE_OFF;
         mode_q     <= MODE_OFF;
         state_q    <= S_OFF;
         tick_cnt_q <= '0;
         pwm_cnt_q  <= '0;
         phase_on_q <= 1'b0;
         led_q      <= 1'b0;
      end else begin
         status_q   <= status_d;
         mode_q     <= mode_d;
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         pwm_cnt_q  <= pwm_cnt_d;
         phase_on_q <= phase_on_d;
         led_q      <= led_d;
      end
   end

   assign led       = led_q;
   assign phase_on  = phase_on_q;
   assign pat_state = state_q;

endmodule

// File: tb/tb_qsys_system_led_driver.sv
module tb_qsys_system_led_driver;

   logic       clk;
   logic       reset_n;
   logic [1:0] status;
   logic [3:0] brightness;
   logic       led;
   logic       phase_on;
   logic [2:0] pat_state;

   int total;
   int bad;

   qsys_system_led_driver #(
      .TICK_DIV      (4),
      .SLOW_TICKS    (3),
      .HB_ON_TICKS   (2),
      .HB_GAP_TICKS  (2),
      .HB_REST_TICKS (6),
      .PWM_BITS      (4)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .status     (status),
      .brightness (brightness),
      .led        (led),
      .phase_on   (phase_on),
      .pat_state  (pat_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Heartbeat with test parameters: P1 8, G1 8, P2 8, REST 24 cycles.
   function automatic logic [2:0] hb_state(input int k);
      int m;
      m = k % 48;
      if (m < 8)       return 3'd4;
      else if (m < 16) return 3'd5;
      else if (m < 24) return 3'd6;
      else             return 3'd7;
   endfunction

   // Slow blink: ON 12 cycles, OFF 12 cycles.
   function automatic logic [2:0] blink_state(input int k);
      return ((k % 24) < 12) ? 3'd2 : 3'd3;
   endfunction

   function automatic logic lit(input logic [2:0] s);
      return (s == 3'd1) || (s == 3'd2) || (s == 3'd4) || (s == 3'd6);
   endfunction

   // Called at the negedge right after HB_P1 entry; leaves at sample k=48.
   task automatic run_hb(input string tag);
      logic [2:0] es;
      for (int k = 0; k < 48; k++) begin
         es = hb_state(k);
         chk($sformatf("%s_state[%0d]", tag, k), 32'(pat_state), 32'(es));
         chk($sformatf("%s_phase[%0d]", tag, k), 32'(phase_on), 32'(lit(es)));
         chk($sformatf("%s_led[%0d]", tag, k), 32'(led), 32'(lit(es)));
         @(negedge clk);
      end
   endtask

   initial begin
      int cnt;
      logic [2:0] es;
      total      = 0;
      bad        = 0;
      reset_n    = 1'b0;
      status     = 2'b11;
      brightness = 4'hF;

      // reset held with heartbeat requested
      repeat (3) begin
         @(negedge clk);
         chk("rst_led", 32'(led), 32'd0);
         chk("rst_phase", 32'(phase_on), 32'd0);
         chk("rst_state", 32'(pat_state), 32'd0);
      end
      reset_n = 1'b1;
      @(negedge clk);
      chk("rel_e1_state", 32'(pat_state), 32'd0);
      chk("rel_e1_phase", 32'(phase_on), 32'd0);
      @(negedge clk);
      chk("rel_e2_state", 32'(pat_state), 32'd4);
      chk("rel_e2_phase", 32'(phase_on), 32'd1);
      run_hb("hb0");
      chk("hb0_wrap", 32'(pat_state), 32'd4);

      // async reset pulse in the middle of HB_REST (sample k=78)
      repeat (30) @(negedge clk);
      chk("pre_rst_rest", 32'(pat_state), 32'd7);
      reset_n = 1'b0;
      #1;
      chk("async_led", 32'(led), 32'd0);
      chk("async_phase", 32'(phase_on), 32'd0);
      chk("async_state", 32'(pat_state), 32'd0);
      @(negedge clk);
      chk("rst_hold_state", 32'(pat_state), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst2_e1_state", 32'(pat_state), 32'd0);
      @(negedge clk);
      run_hb("hb_rst");

      // solid
      status = 2'b01;
      @(negedge clk);
      @(negedge clk);
      chk("solid_state", 32'(pat_state), 32'd1);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("solid_led[%0d]", i), 32'(led), 32'd1);
         @(negedge clk);
      end
      brightness = 4'd4;
      @(negedge clk);
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         cnt += int'(led);
         @(negedge clk);
      end
      chk("pwm4_high_count", 32'(cnt), 32'd4);
      brightness = 4'd0;
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("dark_led[%0d]", i), 32'(led), 32'd0);
         chk($sformatf("dark_phase[%0d]", i), 32'(phase_on), 32'd1);
         @(negedge clk);
      end

      // slow blink
      brightness = 4'hF;
      status     = 2'b10;
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 48; k++) begin
         es = blink_state(k);
         chk($sformatf("blink_state[%0d]", k), 32'(pat_state), 32'(es));
         chk($sformatf("blink_phase[%0d]", k), 32'(phase_on), 32'(lit(es)));
         @(negedge clk);
      end
      // now at k=48; move to k=64, the 5th cycle of BLINK_OFF
      repeat (16) @(negedge clk);
      chk("blink_off_5th", 32'(pat_state), 32'd3);
      status = 2'b11;
      @(negedge clk);
      chk("chg_e1_state", 32'(pat_state), 32'd3);
      @(negedge clk);
      chk("chg_e2_phase", 32'(phase_on), 32'd1);
      run_hb("hb_chg");

      // off
      status = 2'b00;
      @(negedge clk);
      @(negedge clk);
      chk("off_state", 32'(pat_state), 32'd0);
      chk("off_phase", 32'(phase_on), 32'd0);
      chk("off_led", 32'(led), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
